// File: rtl/seq_encoder8_3.sv
`default_nettype none
// ============================================================================
// Module   : seq_encoder8_3
// Purpose  : Sequential 8-to-3 priority encoder. It captures a request vector
//            and emits one set-bit index per valid/ready beat.
//            The popcount output o_count exists only when ENC8_POPCOUNT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seq_encoder8_3 #(
   parameter bit PRIO_LSB = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_vec,
   input  logic       i_ready,
`ifdef ENC8_POPCOUNT_EN
   output logic [3:0] o_count,
`endif
   output logic       o_busy,
   output logic       o_valid,
   output logic [2:0] o_code,
   output logic       o_last,
   output logic       o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_pend, w_pend_nxt, w_served;
   logic [2:0] w_code;
   logic       w_single, w_hs, w_capture;

   // The loop's last hit wins: a descending scan yields the lowest set index.
   always_comb begin
      w_code = 3'd0;
      if (PRIO_LSB) begin
         for (int i = 7; i >= 0; i--) if (r_pend[i]) w_code = 3'(i);
      end else begin
         for (int i = 0; i < 8; i++) if (r_pend[i]) w_code = 3'(i);
      end
   end

   always_comb begin
      w_served         = 8'd0;
      w_served[w_code] = 1'b1;
   end

   assign w_single  = (r_pend != 8'd0) && ((r_pend & (r_pend - 8'd1)) == 8'd0);
   assign w_hs      = o_valid && i_ready;
   assign w_capture = (r_state == S_IDLE) && i_start;

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_vec != 8'd0) begin
                  w_pend_nxt  = i_vec;
                  w_state_nxt = S_EMIT;
               end else begin
                  w_state_nxt = S_FIN;
               end
            end
         end
         S_EMIT: begin
            if (w_hs) begin
               w_pend_nxt = r_pend & ~w_served;
               if (w_single) w_state_nxt = S_FIN;
            end
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pend  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Outputs decode straight from state so reset clears them without a clock.
   assign o_busy  = (r_state != S_IDLE);
   assign o_valid = (r_state == S_EMIT);
   assign o_code  = o_valid ? w_code : 3'd0;
   assign o_last  = o_valid && w_single;
   assign o_done  = (r_state == S_FIN);

`ifdef ENC8_POPCOUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         o_count <= 4'd0;
      else if (w_capture) o_count <= 4'($countones(i_vec));
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_encoder8_3.sv
`default_nettype none
// Testbench for seq_encoder8_3: runs both priority orders in lockstep against a
// queue-based model of the expected index stream.
module tb_seq_encoder8_3;

   logic       clk = 1'b0;
   logic       rst_n, i_start, i_ready;
   logic [7:0] i_vec;
   logic       l_busy, l_valid, l_last, l_done;
   logic       m_busy, m_valid, m_last, m_done;
   logic [2:0] l_code, m_code;
`ifdef ENC8_POPCOUNT_EN
   logic [3:0] l_count, m_count;
`endif
   logic [3:0] exp_count;
   int         n_pass  = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   seq_encoder8_3 #(.PRIO_LSB(1'b1)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_vec(i_vec), .i_ready(i_ready),
`ifdef ENC8_POPCOUNT_EN
      .o_count(l_count),
`endif
      .o_busy(l_busy), .o_valid(l_valid), .o_code(l_code), .o_last(l_last), .o_done(l_done)
   );

   seq_encoder8_3 #(.PRIO_LSB(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_vec(i_vec), .i_ready(i_ready),
`ifdef ENC8_POPCOUNT_EN
      .o_count(m_count),
`endif
      .o_busy(m_busy), .o_valid(m_valid), .o_code(m_code), .o_last(m_last), .o_done(m_done)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic [2:0] ecl,
                             input logic [2:0] ecm, input logic el, input logic eb,
                             input logic ed);
      chk({tag, "/lsb_valid"}, {7'd0, l_valid}, {7'd0, ev});
      chk({tag, "/lsb_code"},  {5'd0, l_code},  {5'd0, ecl});
      chk({tag, "/lsb_last"},  {7'd0, l_last},  {7'd0, el});
      chk({tag, "/lsb_busy"},  {7'd0, l_busy},  {7'd0, eb});
      chk({tag, "/lsb_done"},  {7'd0, l_done},  {7'd0, ed});
      chk({tag, "/msb_valid"}, {7'd0, m_valid}, {7'd0, ev});
      chk({tag, "/msb_code"},  {5'd0, m_code},  {5'd0, ecm});
      chk({tag, "/msb_last"},  {7'd0, m_last},  {7'd0, el});
      chk({tag, "/msb_busy"},  {7'd0, m_busy},  {7'd0, eb});
      chk({tag, "/msb_done"},  {7'd0, m_done},  {7'd0, ed});
`ifdef ENC8_POPCOUNT_EN
      chk({tag, "/lsb_count"}, {4'd0, l_count}, {4'd0, exp_count});
      chk({tag, "/msb_count"}, {4'd0, m_count}, {4'd0, exp_count});
`endif
   endtask

   // Entered and left at a falling edge with both DUTs idle.
   task automatic run_vec(input logic [7:0] v, input int stall, input bit rnd_ready,
                          input bit intr_en, input logic [7:0] intr_vec);
      int ql[$];
      int qm[$];
      int cyc;
      for (int k = 0; k < 8; k++) if (v[k]) ql.push_back(k);
      for (int k = 7; k >= 0; k--) if (v[k]) qm.push_back(k);
      i_start = 1'b1;
      i_vec   = v;
      i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_count = 4'(ql.size());
      i_start   = 1'b0;
      cyc       = 0;
      while (ql.size() > 0) begin
         check_outs("beat", 1'b1, 3'(ql[0]), 3'(qm[0]), ql.size() == 1, 1'b1, 1'b0);
         if (cyc < stall)                  i_ready = 1'b0;
         else if (rnd_ready && cyc < 24)   i_ready = 1'($urandom_range(0, 1));
         else                              i_ready = 1'b1;
         if (intr_en) begin
            i_start = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_vec   = intr_vec;
         end
         @(negedge clk);
         if (i_ready) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
         end
         cyc++;
      end
      i_start = 1'b0;
      check_outs("fin", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_outs("idle", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_vec     = 8'd0;
      i_ready   = 1'b0;
      exp_count = 4'd0;
      repeat (2) @(negedge clk);
      check_outs("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_outs("post_reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

      run_vec(8'hA4, 0, 1'b0, 1'b0, 8'h00);
      run_vec(8'h81, 3, 1'b0, 1'b0, 8'h00);
      run_vec(8'h00, 0, 1'b0, 1'b0, 8'h00);
      run_vec(8'hFF, 0, 1'b0, 1'b0, 8'h00);
      run_vec(8'h0F, 0, 1'b0, 1'b1, 8'hF0);

      // Abandon a stream after two beats with an asynchronous reset.
      i_start = 1'b1;
      i_vec   = 8'h0F;
      i_ready = 1'b1;
      @(negedge clk);
      exp_count = 4'd4;
      i_start   = 1'b0;
      check_outs("rst_beat0", 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_outs("rst_beat1", 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_count = 4'd0;
      check_outs("async_reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      check_outs("reset_held", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outs("no_done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      run_vec(8'h10, 0, 1'b0, 1'b0, 8'h00);
      run_vec(8'hF0, 0, 1'b0, 1'b0, 8'h00);

      for (int t = 0; t < 20; t++)
         run_vec(8'($urandom), $urandom_range(0, 2), 1'b1, 1'b1, 8'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
